// File: rtl/types.sv
// rtl/types.sv - geometry widths and line record shared with the edge-function stages
package types;

  localparam int LINE_BITS   = 11;
  localparam int THRESH_BITS = 10;
  localparam int WORD_BITS   = (LINE_BITS > THRESH_BITS) ? LINE_BITS : THRESH_BITS;

  typedef struct packed {
    logic [LINE_BITS-1:0] x0;
    logic [LINE_BITS-1:0] y0;
    logic [LINE_BITS-1:0] x1;
    logic [LINE_BITS-1:0] y1;
  } line_t;

endpackage

// File: rtl/line_store.sv
// rtl/line_store.sv - double-buffered line set and threshold, swapped at frame start
module line_store
  import types::*;
#(
  parameter int NUM_LINES = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        wr_valid_i,
  output logic                        wr_ready_o,
  input  logic                        wr_first_i,
  input  logic [types::WORD_BITS-1:0] wr_data_i,
  input  logic                        frame_start_i,
  output types::line_t                lines_o [NUM_LINES],
  output logic [types::THRESH_BITS-1:0] thresh_o,
  output logic                        pending_o,
  output logic                        swap_o
);

  localparam int FRAME_WORDS = 4 * NUM_LINES + 1;
  localparam int IDX_BITS    = $clog2(FRAME_WORDS + 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(FRAME_WORDS - 1);

  typedef enum logic {
    ST_LOAD,
    ST_PENDING
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [IDX_BITS-1:0]    wr_idx;
  logic                   shadow_we;
  logic                   swap_d;
  logic [WORD_BITS-1:0]   shadow [FRAME_WORDS];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_idx    = idx_q;
    shadow_we = 1'b0;
    swap_d    = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        // frame_start_i is deliberately ignored here, including on the last word
        if (wr_valid_i && wr_ready_o) begin
          shadow_we = 1'b1;
          if (wr_first_i) begin
            wr_idx = '0;
            idx_d  = IDX_BITS'(1);
          end else begin
            idx_d = idx_q + IDX_BITS'(1);
            if (idx_q == LAST_IDX) state_d = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (frame_start_i) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          swap_d  = 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      wr_ready_o <= 1'b1;
      pending_o  <= 1'b0;
      swap_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wr_ready_o <= (state_d == ST_LOAD) && !swap_d;
      pending_o  <= (state_d == ST_PENDING);
      swap_o     <= swap_d;
    end
  end

  // Shadow contents are only observable after a complete load, so no reset
  always_ff @(posedge clk_i) begin
    if (shadow_we) shadow[wr_idx] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_LINES; k++) lines_o[k] <= '0;
      thresh_o <= '0;
    end else if (swap_d) begin
      for (int k = 0; k < NUM_LINES; k++) begin
        lines_o[k].x0 <= shadow[4*k+0][LINE_BITS-1:0];
        lines_o[k].y0 <= shadow[4*k+1][LINE_BITS-1:0];
        lines_o[k].x1 <= shadow[4*k+2][LINE_BITS-1:0];
        lines_o[k].y1 <= shadow[4*k+3][LINE_BITS-1:0];
      end
      thresh_o <= shadow[FRAME_WORDS-1][THRESH_BITS-1:0];
    end
  end

endmodule
